// File: rtl/guess_game_param.sv
// Number-guessing game core: free-running secret, edge-triggered guess checks,
// attempt limit with win/lose end states and restart without reset.
module guess_game_param #(
  parameter int WIDTH     = 8,
  parameter int MAX_VAL   = 2**WIDTH-1,
  parameter int MAX_TRIES = 7,
  parameter int TRIES_W   = $clog2(MAX_TRIES+1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enter,
  input  logic               restart,
  input  logic [WIDTH-1:0]   guess,
  output logic [WIDTH-1:0]   actual,
  output logic               dp_over,
  output logic               dp_under,
  output logic               dp_equal,
  output logic [TRIES_W-1:0] tries,
  output logic               won,
  output logic               lost
);

  typedef enum logic [2:0] {
    S_GEN,
    S_CHECK,
    S_WAIT,
    S_WIN,
    S_LOSE
  } state_e;

  localparam logic [WIDTH-1:0]   MAX_V = WIDTH'(MAX_VAL);
  localparam logic [TRIES_W-1:0] MAX_T = TRIES_W'(MAX_TRIES);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     actual_q, actual_d;
  logic                 over_q, over_d;
  logic                 under_q, under_d;
  logic                 equal_q, equal_d;
  logic [TRIES_W-1:0]   tries_q, tries_d;
  logic                 enter_q;

  logic                 enter_rise;
  logic [TRIES_W-1:0]   tries_inc;
  logic                 guess_eq;
  logic                 guess_gt;

  assign enter_rise = enter & ~enter_q;
  assign tries_inc  = tries_q + TRIES_W'(1);
  assign guess_eq   = (guess == actual_q);
  assign guess_gt   = (guess >  actual_q);

  // enter_q resets high so a key held through reset is not seen as a press.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its inputs, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_GEN;
      actual_q <= '0;
      over_q   <= 1'b0;
      under_q  <= 1'b0;
      equal_q  <= 1'b0;
      tries_q  <= '0;
      enter_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      actual_q <= actual_d;
      over_q   <= over_d;
      under_q  <= under_d;
      equal_q  <= equal_d;
      tries_q  <= tries_d;
      enter_q  <= enter;
    end
  end

  // NOTE: every signal written here gets a hold default first; a path that
  // skipped an assignment would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    actual_d = actual_q;
    over_d   = over_q;
    under_d  = under_q;
    equal_d  = equal_q;
    tries_d  = tries_q;

    unique case (state_q)
      S_GEN: begin
        if (enter_rise) begin
          state_d = S_CHECK;
        end else begin
          actual_d = (actual_q == MAX_V) ? '0 : actual_q + WIDTH'(1);
        end
      end
      S_CHECK: begin
        over_d  = guess_gt;
        under_d = ~guess_gt & ~guess_eq;
        equal_d = guess_eq;
        tries_d = tries_inc;
        // A correct guess on the last allowed try is a win, not a loss.
        if (guess_eq)                state_d = S_WIN;
        else if (tries_inc == MAX_T) state_d = S_LOSE;
        else                         state_d = S_WAIT;
      end
      S_WAIT: begin
        if (enter_rise) state_d = S_CHECK;
      end
      S_WIN, S_LOSE: begin
        if (restart) begin
          state_d = S_GEN;
          tries_d = '0;
          over_d  = 1'b0;
          under_d = 1'b0;
          equal_d = 1'b0;
        end
      end
      default: state_d = S_GEN;
    endcase
  end

  assign actual   = actual_q;
  assign dp_over  = over_q;
  assign dp_under = under_q;
  assign dp_equal = equal_q;
  assign tries    = tries_q;
  assign won      = (state_q == S_WIN);
  assign lost     = (state_q == S_LOSE);

endmodule
